// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer for the single-cycle datapath.
// Owns the PC, fetches over a req/ack handshake, and grants one execute cycle per instruction.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PC_Plus4,
  output logic        instr_valid,
  input  logic        Jump,
  input  logic [31:0] PC_Jump,
  input  logic        PC_Scr,
  input  logic [31:0] PC_Branch,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired_count
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXECUTE,
    HALT,
    FAULT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] next_pc;

  // Jump outranks a taken branch when the datapath asserts both.
  always_comb begin
    next_pc = pc + 32'd4;
    if (Jump) begin
      next_pc = PC_Jump;
    end else if (PC_Scr) begin
      next_pc = PC_Branch;
    end
  end

  assign imem_addr = pc;
  assign PC_Plus4  = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      Instruction   <= '0;
      imem_req      <= 1'b0;
      instr_valid   <= 1'b0;
      halted        <= 1'b0;
      fault         <= 1'b0;
      retired_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end

        FETCH: begin
          if (imem_ack) begin
            Instruction <= imem_rdata;
            imem_req    <= 1'b0;
            if (imem_rdata[31:26] == HALT_OPCODE) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state       <= EXECUTE;
              instr_valid <= 1'b1;
            end
          end
        end

        EXECUTE: begin
          instr_valid   <= 1'b0;
          retired_count <= retired_count + 32'd1;
          if (next_pc[1:0] != 2'b00) begin
            state <= FAULT;
            fault <= 1'b1;
          end else begin
            pc <= next_pc;
            if (run) begin
              state    <= FETCH;
              imem_req <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        HALT: begin
          imem_req <= 1'b0;
          halted   <= 1'b1;
        end

        FAULT: begin
          imem_req <= 1'b0;
          fault    <= 1'b1;
        end

        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; inputs change and outputs are sampled on the falling edge.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic [31:0] PC_Plus4;
  logic        instr_valid;
  logic        Jump;
  logic [31:0] PC_Jump;
  logic        PC_Scr;
  logic [31:0] PC_Branch;
  logic        halted;
  logic        fault;
  logic [31:0] retired_count;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] NOP  = 32'h0000_1234;
  localparam logic [31:0] HALTW = 32'hFC00_0000;

  fetch_sequencer #(
    .RESET_PC   (32'h0000_0000),
    .HALT_OPCODE(6'b111111)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .Instruction  (Instruction),
    .PC_Plus4     (PC_Plus4),
    .instr_valid  (instr_valid),
    .Jump         (Jump),
    .PC_Jump      (PC_Jump),
    .PC_Scr       (PC_Scr),
    .PC_Branch    (PC_Branch),
    .halted       (halted),
    .fault        (fault),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset      = 1'b1;
    run        = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = NOP;
    Jump       = 1'b0;
    PC_Jump    = '0;
    PC_Scr     = 1'b0;
    PC_Branch  = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", imem_req); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    tests++; if (Instruction !== 32'h0) begin fails++; $display("FAIL reset_instr got %h want 0", Instruction); end
    tests++; if (PC_Plus4 !== 32'h4) begin fails++; $display("FAIL reset_pc4 got %h want 4", PC_Plus4); end
    tests++; if ({instr_valid, halted, fault} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {instr_valid, halted, fault}); end
    tests++; if (retired_count !== 32'h0) begin fails++; $display("FAIL reset_count got %0d want 0", retired_count); end
  endtask

  // Three zero-wait instructions, then run drops mid-FETCH: the 4th still executes, then IDLE.
  task automatic test_sequential_and_run_drop();
    do_reset();
    run = 1'b1; imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      imem_rdata = 32'h0000_1000 + i;
      tests++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i) || instr_valid !== 1'b0) begin
        fails++; $display("FAIL seq_fetch%0d req=%b addr=%h valid=%b want 1/%h/0", i, imem_req, imem_addr, instr_valid, 4 * i);
      end
      @(negedge clk);
      tests++; if (instr_valid !== 1'b1 || Instruction !== 32'h0000_1000 + i || imem_addr !== 32'(4 * i)) begin
        fails++; $display("FAIL seq_exec%0d valid=%b instr=%h addr=%h", i, instr_valid, Instruction, imem_addr);
      end
    end
    @(negedge clk);
    tests++; if (retired_count !== 32'd3 || imem_addr !== 32'hC) begin
      fails++; $display("FAIL seq_count got %0d addr %h want 3 addr c", retired_count, imem_addr);
    end
    tests++; if (Instruction !== 32'h0000_1002) begin fails++; $display("FAIL instr_stable_fetch got %h want 00001002", Instruction); end
    run = 1'b0;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL rundrop_exec valid=%b want 1", instr_valid); end
    @(negedge clk);
    tests++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h10 || retired_count !== 32'd4) begin
      fails++; $display("FAIL rundrop_idle req=%b valid=%b addr=%h count=%0d want 0/0/10/4", imem_req, instr_valid, imem_addr, retired_count);
    end
    @(negedge clk);
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rundrop_hold req=%b want 0", imem_req); end
  endtask

  task automatic test_branch_jump();
    do_reset();
    run = 1'b1; imem_ack = 1'b1;
    @(negedge clk);
    Jump = 1'b1; PC_Jump = 32'h40; PC_Scr = 1'b1; PC_Branch = 32'h100;
    @(negedge clk);
    @(negedge clk);
    tests++; if (imem_addr !== 32'h40) begin fails++; $display("FAIL jump_priority got %h want 00000040", imem_addr); end
    Jump = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (imem_addr !== 32'h100 || PC_Plus4 !== 32'h104) begin
      fails++; $display("FAIL branch_taken addr=%h pc4=%h want 100/104", imem_addr, PC_Plus4);
    end
    PC_Scr = 1'b0; Jump = 1'b1; PC_Jump = 32'hFFFF_FFFC;
    @(negedge clk);
    @(negedge clk);
    tests++; if (imem_addr !== 32'hFFFF_FFFC || PC_Plus4 !== 32'h0) begin
      fails++; $display("FAIL pc4_wrap addr=%h pc4=%h want fffffffc/0", imem_addr, PC_Plus4);
    end
    Jump = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (imem_addr !== 32'h0 || retired_count !== 32'd4) begin
      fails++; $display("FAIL seq_wrap addr=%h count=%0d want 0/4", imem_addr, retired_count);
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
        fails++; $display("FAIL wait%0d req=%b addr=%h valid=%b want 1/0/0", k, imem_req, imem_addr, instr_valid);
      end
      if (k == 3) imem_ack = 1'b1;
    end
    @(negedge clk);
    imem_ack = 1'b0; run = 1'b0;
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL wait_exec valid=%b want 1", instr_valid); end
    @(negedge clk);
    tests++; if (instr_valid !== 1'b0 || retired_count !== 32'd1) begin
      fails++; $display("FAIL wait_single valid=%b count=%0d want 0/1", instr_valid, retired_count);
    end
    imem_ack = 1'b1; imem_rdata = HALTW;
    @(negedge clk);
    @(negedge clk);
    tests++; if (halted !== 1'b0 || Instruction !== NOP || imem_req !== 1'b0) begin
      fails++; $display("FAIL stray_ack halted=%b instr=%h req=%b want 0/%h/0", halted, Instruction, imem_req, NOP);
    end
  endtask

  task automatic test_halt();
    do_reset();
    run = 1'b1; imem_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    imem_rdata = HALTW;
    @(negedge clk);
    tests++; if (imem_addr !== 32'h4) begin fails++; $display("FAIL halt_fetch_addr got %h want 4", imem_addr); end
    @(negedge clk);
    tests++; if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || retired_count !== 32'd1 || Instruction !== HALTW) begin
      fails++; $display("FAIL halt_enter halted=%b req=%b valid=%b count=%0d instr=%h", halted, imem_req, instr_valid, retired_count, Instruction);
    end
    repeat (3) @(negedge clk);
    tests++; if (halted !== 1'b1 || imem_req !== 1'b0 || retired_count !== 32'd1) begin
      fails++; $display("FAIL halt_hold halted=%b req=%b count=%0d want 1/0/1", halted, imem_req, retired_count);
    end
    do_reset();
    tests++; if (halted !== 1'b0 || imem_addr !== 32'h0) begin
      fails++; $display("FAIL halt_reset halted=%b addr=%h want 0/0", halted, imem_addr);
    end
  endtask

  task automatic test_fault();
    do_reset();
    run = 1'b1; imem_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    Jump = 1'b1; PC_Jump = 32'h42;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1 || imem_addr !== 32'h4) begin
      fails++; $display("FAIL fault_exec valid=%b addr=%h want 1/4", instr_valid, imem_addr);
    end
    @(negedge clk);
    tests++; if (fault !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h4 || retired_count !== 32'd2) begin
      fails++; $display("FAIL fault_enter fault=%b req=%b addr=%h count=%0d want 1/0/4/2", fault, imem_req, imem_addr, retired_count);
    end
    Jump = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (fault !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
      fails++; $display("FAIL fault_hold fault=%b req=%b addr=%h valid=%b", fault, imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    run = 1'b1; imem_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      fails++; $display("FAIL midfetch_pre req=%b addr=%h want 1/4", imem_req, imem_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || retired_count !== 32'd0) begin
      fails++; $display("FAIL midfetch_reset req=%b addr=%h count=%0d want 0/0/0", imem_req, imem_addr, retired_count);
    end
    reset = 1'b0; run = 1'b0; imem_ack = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || Instruction !== 32'h0 || imem_addr !== 32'h0) begin
      fails++; $display("FAIL late_ack req=%b valid=%b instr=%h addr=%h want 0/0/0/0", imem_req, instr_valid, Instruction, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_sequential_and_run_drop();
    test_branch_jump();
    test_wait_states();
    test_halt();
    test_fault();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
